dir_write_counter: RTL

- Address-sequencing stage directly upstream of the write-address decoder (Dir_escritura).
- Generates the binary register index (`binary_out`) and the decoder enable (`en_out`) that feed the decoder's `binary_in` and `EN`.
- Steps through a contiguous address window [MIN_ADDR..MAX_ADDR], one address per `advance` strobe, so the decoder asserts exactly one write-select line at a time during an RTC register write burst.

---
 rtl/dir_write_counter_pkg.sv | 23 ++
 rtl/dir_write_counter_if.sv | 27 ++
 rtl/dir_write_counter_updown.sv | 47 ++++
 rtl/dir_write_counter.sv | 115 +++++++++++
 4 files changed

// File: rtl/dir_write_counter_pkg.sv
// dir_write_counter_pkg
//   Shared definitions for the write-address sequencer that feeds the
//   Dir_escritura decoder: FSM state encoding, the default RTC register
//   window and a helper returning the first address of a burst.
//   No ports (package).
package dir_write_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Default RTC register window, shared with the decoder wrapper.
  localparam int RTC_WIN_MIN = 0;
  localparam int RTC_WIN_MAX = 8;

  // Ascending bursts begin at the low bound, descending at the high bound.
  function automatic int start_addr(input logic up, input int lo, input int hi);
    return up ? lo : hi;
  endfunction

endpackage

// File: rtl/dir_write_counter_if.sv
// dir_write_counter_if
//   Control/address bundle between a burst controller (master) and the
//   address sequencer (slave).
//   master -> slave : start, dir_up, advance, stop
//   slave -> master : binary_out[ADDR_W], en_out, busy, done
interface dir_write_counter_if #(parameter int ADDR_W = 4);

  logic              start;
  logic              dir_up;
  logic              advance;
  logic              stop;
  logic [ADDR_W-1:0] binary_out;
  logic              en_out;
  logic              busy;
  logic              done;

  modport master (
    output start, dir_up, advance, stop,
    input  binary_out, en_out, busy, done
  );

  modport slave (
    input  start, dir_up, advance, stop,
    output binary_out, en_out, busy, done
  );

endinterface

// File: rtl/dir_write_counter_updown.sv
// updown_mod_counter
//   Loadable up/down address counter bounded by [MIN_ADDR..MAX_ADDR].
//   clk, reset     : clock, async active-high reset (count -> 0)
//   load/load_value: synchronous load, has priority over step
//   step, dir      : move one address, dir=1 up, dir=0 down
//   count          : registered current address
//   terminal       : count sits on the last address for direction dir
module updown_mod_counter #(
  parameter int ADDR_W   = 4,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (step) begin
      count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the register only, so it never depends on live inputs.
  assign terminal = dir ? (count_q == ADDR_W'(MAX_ADDR))
                        : (count_q == ADDR_W'(MIN_ADDR));
  assign count    = count_q;

endmodule

// File: rtl/dir_write_counter.sv
// dir_write_counter
//   Steps the write-address decoder through [MIN_ADDR..MAX_ADDR], one
//   address per advance strobe, ascending or descending, optionally wrapping.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of dir_write_counter_if
//           (start, dir_up, advance, stop in; binary_out, en_out, busy, done out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no burst; en_out low, binary_out holds last address
//   S_RUN  | burst active; en_out high, address moves on advance
//   S_DONE | single-pass burst finished; done pulses for one cycle
module dir_write_counter
  import dir_write_counter_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int MIN_ADDR = RTC_WIN_MIN,
  parameter int MAX_ADDR = RTC_WIN_MAX,
  parameter int WRAP     = 0
) (
  input  logic               clk,
  input  logic               reset,
  dir_write_counter_if.slave bus
);

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_load;
  logic [ADDR_W-1:0] cnt_load_value;
  logic              cnt_step;
  logic [ADDR_W-1:0] cnt_value;
  logic              cnt_terminal;

  updown_mod_counter #(
    .ADDR_W   (ADDR_W),
    .MIN_ADDR (MIN_ADDR),
    .MAX_ADDR (MAX_ADDR)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .step       (cnt_step),
    .dir        (dir_q),
    .count      (cnt_value),
    .terminal   (cnt_terminal)
  );

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    cnt_load       = 1'b0;
    cnt_step       = 1'b0;
    cnt_load_value = ADDR_W'(start_addr(dir_q, MIN_ADDR, MAX_ADDR));
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dir_d          = bus.dir_up;
          cnt_load       = 1'b1;
          cnt_load_value = ADDR_W'(start_addr(bus.dir_up, MIN_ADDR, MAX_ADDR));
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        // stop wins over a coincident advance
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.advance) begin
          if (cnt_terminal) begin
            if (WRAP != 0) begin
              cnt_load = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs follow the next state so they are registered alongside it.
    en_d   = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.binary_out = cnt_value;
  assign bus.en_out     = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
